// File: rtl/uart_rx_if.sv
// Bus bundle between the UART receiver and its consumer: serial input,
// byte handshake and status flags.
interface uart_rx_if;
    logic       rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_overrun;
    logic       rx_frame_err;
    logic       rx_busy;

    // Consumer side: drives the line and the accept strobe.
    modport master (
        output rx,
        output rx_ready,
        input  rx_data,
        input  rx_valid,
        input  rx_overrun,
        input  rx_frame_err,
        input  rx_busy
    );

    // Receiver side.
    modport slave (
        input  rx,
        input  rx_ready,
        output rx_data,
        output rx_valid,
        output rx_overrun,
        output rx_frame_err,
        output rx_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. The line is synchronised by two flops and
// sampled mid-bit using a counter derived from clk_rate / baud_rate.
// A received byte is held with a level valid flag until the consumer
// accepts it; an unconsumed byte that gets replaced raises an overrun flag.
module uart_rx #(
    parameter int clk_rate  = 100000000,
    parameter int baud_rate = 115200
) (
    input  logic     clk,
    input  logic     rst,
    uart_rx_if.slave bus
);

    localparam int CLK_DIV  = clk_rate / baud_rate;
    localparam int HALF_DIV = CLK_DIV / 2;
    localparam int CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_t;

    // Synchroniser
    logic             rx_meta_q;
    logic             rx_s_q;

    // Frame sequencing
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             complete_s;

    // Consumer-facing registers
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;
    logic             handshake_s;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM next state: start qualification, data shifting, stop check.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        ferr_d     = 1'b0;
        complete_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                idx_d = 3'd0;
                if (!rx_s_q) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = CNT_ZERO;
                    // Still low at mid start bit: a real frame. High: a glitch.
                    if (!rx_s_q) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d          = CNT_ZERO;
                    shift_d[idx_q] = rx_s_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = CNT_ZERO;
                    if (rx_s_q) begin
                        complete_s = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        // Bad stop bit: flag it and wait out any break.
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT_HIGH: begin
                cnt_d = CNT_ZERO;
                idx_d = 3'd0;
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Output register next state: byte load, overrun tracking, handshake.
    always_comb begin
        handshake_s = valid_q && bus.rx_ready;
        data_d      = data_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;
        if (complete_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // Overrun only if the pending byte was not taken this same cycle;
            // a simultaneous accept also retires any earlier overrun.
            if (valid_q && !bus.rx_ready) begin
                ovr_d = 1'b1;
            end else begin
                ovr_d = 1'b0;
            end
        end else if (handshake_s) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            valid_d = valid_q;
            ovr_d   = ovr_q;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    assign bus.rx_data      = data_q;
    assign bus.rx_valid     = valid_q;
    assign bus.rx_overrun   = ovr_q;
    assign bus.rx_frame_err = ferr_q;
    assign bus.rx_busy      = (state_q != ST_IDLE);

endmodule
